// File: rtl/wbgpio_irq.sv
// Wishbone GPIO block with synchronised inputs, set/clear outputs and sticky edge interrupts.
// Optional per-pin input debounce is compiled in when WBGPIO_DEBOUNCE_EN is defined.
module wbgpio_irq #(
    parameter int              NIN        = 16,
    parameter int              NOUT       = 16,
    parameter logic [NOUT-1:0] DEFAULT    = '0,
    parameter int              LGDEBOUNCE = 4
) (
    input  logic            i_clk,
    input  logic            i_reset_n,
    input  logic            i_wb_cyc,
    input  logic            i_wb_stb,
    input  logic            i_wb_we,
    input  logic [2:0]      i_wb_addr,
    input  logic [31:0]     i_wb_data,
    output logic            o_wb_stall,
    output logic            o_wb_ack,
    output logic [31:0]     o_wb_data,
    input  logic [NIN-1:0]  i_gpio,
    output logic [NOUT-1:0] o_gpio,
    output logic            o_int
);

    // Bus handshake: a transfer happens on every cycle with cyc && stb; the slave
    // never stalls and acks each transfer exactly one cycle later, with read data.
    logic            w_stb;
    logic            w_wr;
    logic [NIN-1:0]  w_wdat_in;
    logic [NOUT-1:0] w_wdat_out;
    logic [NIN-1:0]  w_in;
    logic [NIN-1:0]  w_edge;
    logic [NIN-1:0]  w_clr;
    logic [31:0]     w_rdata;
    logic            w_unused;

    logic [NIN-1:0]  r_x;
    logic [NIN-1:0]  r_q;
    logic [NIN-1:0]  r_p;
    logic [NIN-1:0]  r_ipend;
    logic [NIN-1:0]  r_irise;
    logic [NIN-1:0]  r_ifall;
    logic [NOUT-1:0] r_gpio;
    logic            r_int;
    logic            r_ack;
    logic [31:0]     r_rdata;

    assign w_stb      = i_wb_cyc && i_wb_stb;
    assign w_wr       = w_stb && i_wb_we;
    assign w_wdat_in  = i_wb_data[NIN-1:0];
    assign w_wdat_out = i_wb_data[NOUT-1:0];
    assign w_unused   = &{1'b0, i_wb_data, LGDEBOUNCE[0]};

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_x <= '0;
            r_q <= '0;
        end else begin
            r_x <= i_gpio;
            r_q <= r_x;
        end
    end

`ifdef WBGPIO_DEBOUNCE_EN
    // A pin's debounced level follows q only after 2^LGDEBOUNCE consecutive disagreeing cycles.
    logic [NIN-1:0]        r_db;
    logic [LGDEBOUNCE-1:0] r_cnt [NIN];

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_db <= '0;
            for (int i = 0; i < NIN; i++) r_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < NIN; i++) begin
                if (r_q[i] == r_db[i]) begin
                    r_cnt[i] <= '0;
                end else if (&r_cnt[i]) begin
                    r_db[i]  <= r_q[i];
                    r_cnt[i] <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + LGDEBOUNCE'(1);
                end
            end
        end
    end

    assign w_in = r_db;
`else
    assign w_in = r_q;
`endif

    assign w_edge = (w_in & ~r_p & r_irise) | (~w_in & r_p & r_ifall);
    assign w_clr  = (w_wr && (i_wb_addr == 3'd4)) ? w_wdat_in : '0;

    // New edges win over a simultaneous write-1-to-clear of the same bit.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_p     <= '0;
            r_ipend <= '0;
            r_int   <= 1'b0;
        end else begin
            r_p     <= w_in;
            r_ipend <= (r_ipend & ~w_clr) | w_edge;
            r_int   <= |r_ipend;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_gpio  <= DEFAULT;
            r_irise <= '0;
            r_ifall <= '0;
        end else if (w_wr) begin
            case (i_wb_addr)
                3'd1:    r_gpio  <= w_wdat_out;
                3'd2:    r_gpio  <= r_gpio | w_wdat_out;
                3'd3:    r_gpio  <= r_gpio & ~w_wdat_out;
                3'd5:    r_irise <= w_wdat_in;
                3'd6:    r_ifall <= w_wdat_in;
                default: ;
            endcase
        end
    end

    always_comb begin
        w_rdata = '0;
        case (i_wb_addr)
            3'd0:    w_rdata[NIN-1:0]  = w_in;
            3'd1:    w_rdata[NOUT-1:0] = r_gpio;
            3'd4:    w_rdata[NIN-1:0]  = r_ipend;
            3'd5:    w_rdata[NIN-1:0]  = r_irise;
            3'd6:    w_rdata[NIN-1:0]  = r_ifall;
            default: ;
        endcase
    end

    // Read data is captured from pre-write contents so a same-cycle write is not visible.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_ack   <= 1'b0;
            r_rdata <= '0;
        end else begin
            r_ack <= w_stb;
            if (w_stb) r_rdata <= w_rdata;
        end
    end

    assign o_wb_stall = 1'b0;
    assign o_wb_ack   = r_ack;
    assign o_wb_data  = r_rdata;
    assign o_gpio     = r_gpio;
    assign o_int      = r_int;

endmodule

// File: tb/tb_wbgpio_irq.sv
// Scoreboard bench for wbgpio_irq: a per-edge behavioural model queues expected read data,
// a negedge monitor pops it on every ack and checks pins, interrupt and ack every cycle.
module tb_wbgpio_irq;

  localparam logic [15:0] DEF = 16'h00A5;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        cyc = 1'b0;
  logic        stb = 1'b0;
  logic        we = 1'b0;
  logic [2:0]  addr = '0;
  logic [31:0] wdat = '0;
  logic [15:0] gpio = '0;
  logic        o_wb_stall;
  logic        o_wb_ack;
  logic [31:0] o_wb_data;
  logic [15:0] o_gpio;
  logic        o_int;

  int n_checks = 0;
  int n_fail = 0;
  bit started = 1'b0;

  logic [31:0] exp_q[$];

  wbgpio_irq #(
    .NIN(16), .NOUT(16), .DEFAULT(DEF), .LGDEBOUNCE(2)
  ) dut (
    .i_clk(clk), .i_reset_n(rst_n),
    .i_wb_cyc(cyc), .i_wb_stb(stb), .i_wb_we(we),
    .i_wb_addr(addr), .i_wb_data(wdat),
    .o_wb_stall(o_wb_stall), .o_wb_ack(o_wb_ack), .o_wb_data(o_wb_data),
    .i_gpio(gpio), .o_gpio(o_gpio), .o_int(o_int)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // reference model: pin history, register contents and sticky pending bits
  logic [15:0] m_out = DEF;
  logic [15:0] m_irise = '0;
  logic [15:0] m_ifall = '0;
  logic [15:0] m_ipend = '0;
  logic [15:0] m_h [4] = '{default: '0};
  logic        m_int = 1'b0;
  logic        m_ack = 1'b0;
  logic [15:0] m_db = '0;
  logic [15:0] m_dbp = '0;
  int          m_run [16] = '{default: 0};

  always @(posedge clk or negedge rst_n) begin : model
    logic [15:0] cur;
    logic [15:0] prv;
    logic [15:0] edges;
    logic [15:0] clr;
    logic [31:0] rd;
    logic        strobe;
    if (!rst_n) begin
      m_out = DEF; m_irise = '0; m_ifall = '0; m_ipend = '0;
      for (int k = 0; k < 4; k++) m_h[k] = '0;
      m_int = 1'b0; m_ack = 1'b0; m_db = '0; m_dbp = '0;
      for (int k = 0; k < 16; k++) m_run[k] = 0;
      exp_q.delete();
    end else begin
      strobe = cyc && stb;
`ifdef WBGPIO_DEBOUNCE_EN
      cur = m_db;
      prv = m_dbp;
`else
      cur = m_h[1];   // pins seen two edges ago
      prv = m_h[2];
`endif
      m_int = (m_ipend != 16'h0);
      m_ack = strobe;
      if (strobe) begin
        rd = 32'h0;
        case (addr)
          3'd0: rd = {16'h0, cur};
          3'd1: rd = {16'h0, m_out};
          3'd4: rd = {16'h0, m_ipend};
          3'd5: rd = {16'h0, m_irise};
          3'd6: rd = {16'h0, m_ifall};
          default: rd = 32'h0;
        endcase
        exp_q.push_back(rd);
      end
      edges = '0;
      for (int n = 0; n < 16; n++) begin
        if (cur[n] && !prv[n] && m_irise[n]) edges[n] = 1'b1;
        if (!cur[n] && prv[n] && m_ifall[n]) edges[n] = 1'b1;
      end
      clr = (strobe && we && addr == 3'd4) ? wdat[15:0] : 16'h0;
      m_ipend = (m_ipend & ~clr) | edges;
      if (strobe && we) begin
        case (addr)
          3'd1: m_out = wdat[15:0];
          3'd2: m_out = m_out | wdat[15:0];
          3'd3: m_out = m_out & ~wdat[15:0];
          3'd5: m_irise = wdat[15:0];
          3'd6: m_ifall = wdat[15:0];
          default: ;
        endcase
      end
`ifdef WBGPIO_DEBOUNCE_EN
      m_dbp = m_db;
      for (int n = 0; n < 16; n++) begin
        if (m_h[1][n] != m_db[n]) begin
          m_run[n] = m_run[n] + 1;
          if (m_run[n] == 4) begin
            m_db[n] = m_h[1][n];
            m_run[n] = 0;
          end
        end else begin
          m_run[n] = 0;
        end
      end
`endif
      m_h[3] = m_h[2];
      m_h[2] = m_h[1];
      m_h[1] = m_h[0];
      m_h[0] = gpio;
    end
  end

  // monitor
  always @(negedge clk) begin
    if (started && rst_n) begin
      check("o_gpio", {16'h0, o_gpio}, {16'h0, m_out});
      check("o_int", {31'h0, o_int}, {31'h0, m_int});
      check("o_wb_ack", {31'h0, o_wb_ack}, {31'h0, m_ack});
      check("o_wb_stall", {31'h0, o_wb_stall}, 32'h0);
      if (o_wb_ack) begin
        if (exp_q.size() == 0) check("ack_without_request", 32'h1, 32'h0);
        else check("o_wb_data", o_wb_data, exp_q.pop_front());
      end
    end
  end

  // driver tasks
  task automatic tick(input logic c, input logic s, input logic w,
                      input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    cyc = c; stb = s; we = w; addr = a; wdat = d;
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    tick(1'b1, 1'b1, 1'b1, a, d);
  endtask

  task automatic rd(input logic [2:0] a);
    tick(1'b1, 1'b1, 1'b0, a, $urandom);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 1'b0, 3'd0, 32'h0);
  endtask

  initial begin
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    started = 1'b1;
    #1;
    check("reset_o_gpio", {16'h0, o_gpio}, 32'h0000_00A5);
    check("reset_o_int", {31'h0, o_int}, 32'h0);

    rd(3'd4); rd(3'd5); rd(3'd6); rd(3'd7);
    wr(3'd1, 32'h0000_00F0); wr(3'd2, 32'h0000_0003); wr(3'd3, 32'h0000_0010);
    rd(3'd1); rd(3'd2); rd(3'd3);
    idle(2);
    check("oset_oclr_out", {16'h0, o_gpio}, 32'h0000_00E3);

    // rising edge interrupt and clear
    wr(3'd5, 32'h1);
    idle(1); gpio[0] = 1'b1;
    idle(4);
    rd(3'd0); rd(3'd4);
    wr(3'd4, 32'h1);
    idle(3);
    rd(3'd4);

    // masked toggles, then late enable
    wr(3'd5, 32'h0); wr(3'd6, 32'h0);
    idle(1); gpio[3] = 1'b1;
    idle(3); gpio[3] = 1'b0;
    idle(4);
    wr(3'd6, 32'h8);
    idle(4);
    rd(3'd4);

    // W1C colliding with a fresh falling edge on pin 2
    wr(3'd5, 32'h4); wr(3'd6, 32'h4);
    idle(1); gpio[2] = 1'b1;
    idle(5);
    idle(1); gpio[2] = 1'b0;
    idle(1);
    wr(3'd4, 32'h4);
    idle(2);
    rd(3'd4);
    idle(2);
    check("collision_o_int", {31'h0, o_int}, 32'h1);
    wr(3'd4, 32'hFFFF);
    idle(3);

`ifdef WBGPIO_DEBOUNCE_EN
    wr(3'd5, 32'h2);
    idle(1); gpio[1] = 1'b1;
    idle(3); gpio[1] = 1'b0;
    idle(8);
    rd(3'd0); rd(3'd4);
    idle(1); gpio[1] = 1'b1;
    idle(6);
    idle(4);
    rd(3'd0);
    idle(2);
`endif

    // reset in the middle of a transaction
    rd(3'd1);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("midreset_ack", {31'h0, o_wb_ack}, 32'h0);
    check("midreset_o_gpio", {16'h0, o_gpio}, 32'h0000_00A5);
    check("midreset_o_int", {31'h0, o_int}, 32'h0);
    rd(3'd1); rd(3'd0);
    idle(1);
    check("reset_no_ack", {31'h0, o_wb_ack}, 32'h0);
    rst_n = 1'b1;
    idle(2);

    // randomized traffic
    for (int it = 0; it < 1500; it++) begin
      if ($urandom_range(0, 9) < 5) begin
        tick($urandom_range(0, 7) != 0, $urandom_range(0, 7) != 0, $urandom_range(0, 1) == 1,
             3'($urandom_range(0, 7)), $urandom);
      end else begin
        idle(1);
      end
      if ($urandom_range(0, 3) == 0) gpio[$urandom_range(0, 15)] ^= 1'b1;
    end

    idle(4);
    check("scoreboard_drained", exp_q.size(), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/wbgpio_irq.md
WBGPIO_IRQ -- requirements
Module: wbgpio_irq

Interface
REQ-001 SHALL provide parameter NIN, default 16, input pin count (1..32).
REQ-002 SHALL provide parameter NOUT, default 16, output pin count (1..32).
REQ-003 SHALL provide parameter [NOUT-1:0] DEFAULT, default 0, output value on reset.
REQ-004 SHALL provide parameter LGDEBOUNCE, default 4, debounce counter width (used only under WBGPIO_DEBOUNCE_EN).
REQ-005 SHALL have port i_clk, input, 1, sole clock; all flops on its rising edge.
REQ-006 SHALL have port i_reset_n, input, 1, reset: asynchronous assert, active-low.
REQ-007 SHALL have ports i_wb_cyc, i_wb_stb, i_wb_we, input, 1 each, Wishbone pipelined control.
REQ-008 SHALL have port i_wb_addr, input, 3, word register select.
REQ-009 SHALL have port i_wb_data, input, 32, write data.
REQ-010 SHALL have ports o_wb_stall (1), o_wb_ack (1), o_wb_data (32), outputs, bus response.
REQ-011 SHALL have port i_gpio, input, NIN, asynchronous input pins.
REQ-012 SHALL have port o_gpio, output, NOUT, registered output pins.
REQ-013 SHALL have port o_int, output, 1, registered level interrupt.

Function
REQ-014 SHALL define the access strobe as i_wb_cyc && i_wb_stb, and write as strobe && i_wb_we.
REQ-015 SHALL tie o_wb_stall to 0 and assert o_wb_ack exactly one cycle after each strobe, with ack forced 0 the cycle after i_wb_cyc is low.
REQ-016 SHALL register o_wb_data on the strobe cycle, valid with o_wb_ack; bits above NIN/NOUT read 0 and are ignored on write.
REQ-017 SHALL decode the register map: 0 IN (RO, synced inputs), 1 OUT (RW, replaces o_gpio), 2 OSET (WO, o_gpio |= data, reads 0), 3 OCLR (WO, o_gpio &= ~data, reads 0), 4 IPEND (R, write-1-to-clear), 5 IRISE (RW enable), 6 IFALL (RW enable), 7 reserved (reads 0, writes ignored).
REQ-018 SHALL synchronise i_gpio through two flops (x, q); q is the IN value; a third flop p holds the prior q.
REQ-019 SHALL set IPEND[n] when (q[n] & ~p[n] & IRISE[n]) | (~q[n] & p[n] & IFALL[n]); bits are sticky until cleared.
REQ-020 SHALL give set priority when an edge and a W1C hit the same IPEND bit in the same cycle; the bit stays 1.
REQ-021 SHALL register o_int <= |IPEND, one cycle after IPEND changes.
REQ-022 SHALL, from i_gpio change before edge k, reflect it in IN at edge k+1, IPEND at edge k+2, o_int at edge k+3.
REQ-023 SHALL not set IPEND on edges occurring while the bit's enable is 0; enabling later SHALL not create retroactive pending.
REQ-024 SHALL accept a read and return pre-write contents when reading a RW register on the same cycle it was last written.

Reset
REQ-025 SHALL on i_reset_n low, immediately: o_gpio=DEFAULT; IPEND, IRISE, IFALL, x, q, p = 0; o_int=0; o_wb_ack=0; o_wb_data=0.
REQ-026 SHALL drop any in-flight ack on reset mid-transaction; no ack issued for a strobe during reset.
REQ-027 SHALL release reset synchronously-safe: first normal update on the first i_clk edge with i_reset_n high.

Configuration
REQ-028 SHALL, with WBGPIO_DEBOUNCE_EN defined, insert per-pin debounce between q and the IN/edge logic: debounced bit changes only after q differs from it for 2^LGDEBOUNCE consecutive cycles; counter restarts on any bounce; adds that latency to REQ-022.
REQ-029 SHALL, without WBGPIO_DEBOUNCE_EN, omit debounce logic entirely and meet REQ-022 latency exactly.

Verification
REQ-030 SHALL cover reset: DEFAULT=16'h00A5, release reset -> o_gpio=0x00A5, o_int=0, all reads of 4/5/6 return 0.
REQ-031 SHALL cover OSET/OCLR: write OUT=0x00F0, OSET 0x0003, OCLR 0x0010 -> OUT reads 0x00E3, each with one-cycle ack.
REQ-032 SHALL cover rise IRQ: IRISE=0x1, i_gpio[0] 0->1 -> o_int high 3 edges later, IPEND reads 0x1; write IPEND 0x1 -> o_int low 2 cycles later.
REQ-033 SHALL cover masking: IFALL=0, IRISE=0, toggle i_gpio[3] -> IPEND stays 0; enable IFALL[3] afterwards -> still 0.
REQ-034 SHALL cover collision: W1C to IPEND[2] on same cycle as new enabled edge on pin 2 -> IPEND[2]=1, o_int stays 1.
REQ-035 SHALL cover debounce (macro on, LGDEBOUNCE=2): 3-cycle glitch on i_gpio[1] -> IN unchanged, no IPEND; 6-cycle pulse -> IN bit 1 set.
